// File: rtl/code_entry_fsm_if.sv
// Keypad bus between the input sanitizer side and the code entry FSM:
// debounced keypad byte in, lock status out.
interface code_entry_if;
    logic [7:0] signal_in;
    logic       unlocked;
    logic       alarm;
    logic       locked_out;
    logic [2:0] state;
    logic [2:0] fail_count;
    logic [1:0] entry_idx;

    modport master (
        output signal_in,
        input  unlocked, alarm, locked_out, state, fail_count, entry_idx
    );

    modport slave (
        input  signal_in,
        output unlocked, alarm, locked_out, state, fail_count, entry_idx
    );
endinterface

// File: rtl/code_entry_fsm.sv
// Keypad authentication: four ENTER-latched digits, constant-time code
// compare, timed denial, and lockout after repeated failures.
module code_entry_fsm #(
    parameter logic [15:0] CODE           = 16'hA5C3,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned ENTRY_TIMEOUT  = 25_000_000,
    parameter int unsigned DENY_HOLD      = 16,
    parameter int unsigned LOCKOUT_CYCLES = 25_000_000
) (
    input logic         clk,
    input logic         rst_n,
    code_entry_if.slave bus
);
    localparam int unsigned CNT_W = 25;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ENTRY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DENY_LAST    = CNT_W'(DENY_HOLD - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]       MAX_F        = 3'(MAX_FAILS);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        CHECK   = 3'd2,
        GRANTED = 3'd3,
        DENIED  = 3'd4,
        LOCKOUT = 3'd5
    } state_e;

    // Raw register so the illegal codes 6/7 stay representable and reachable.
    logic [2:0]       state_q;
    state_e           state_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      digits_q, digits_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       fail_q, fail_d;
    logic             abort_q, abort_d;
    logic             prev_enter_q, prev_relock_q;

    logic       enter_rise, relock_rise, match;
    logic [2:0] fail_inc;
    logic [3:0] digit;
    logic       unused_bits;

    assign digit       = bus.signal_in[3:0];
    assign enter_rise  = bus.signal_in[7] & ~prev_enter_q;
    assign relock_rise = bus.signal_in[6] & ~prev_relock_q;
    assign unused_bits = ^bus.signal_in[5:4];
    // Full-width XOR reduction: latency independent of which digit is wrong.
    assign match       = ~(|(digits_q ^ CODE)) & ~abort_q;
    assign fail_inc    = (fail_q == 3'd7) ? fail_q : fail_q + 3'd1;

    always_comb begin
        state_d  = state_e'(state_q);
        idx_d    = idx_q;
        digits_d = digits_q;
        cnt_d    = cnt_q;
        fail_d   = fail_q;
        abort_d  = abort_q;
        case (state_q)
            IDLE: begin
                if (enter_rise) begin
                    digits_d = {digits_q[11:0], digit};
                    idx_d    = 2'd1;
                    cnt_d    = '0;
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                if (enter_rise) begin
                    digits_d = {digits_q[11:0], digit};
                    cnt_d    = '0;
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        abort_d = 1'b0;
                        state_d = CHECK;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    abort_d = 1'b1;
                    idx_d   = 2'd0;
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CHECK: begin
                digits_d = '0;
                cnt_d    = '0;
                if (match) begin
                    fail_d  = '0;
                    state_d = GRANTED;
                end else begin
                    fail_d  = fail_inc;
                    state_d = (fail_inc >= MAX_F) ? LOCKOUT : DENIED;
                end
            end
            GRANTED: begin
                if (relock_rise) state_d = IDLE;
            end
            DENIED: begin
                if (cnt_q == DENY_LAST) state_d = IDLE;
                else                    cnt_d   = cnt_q + CNT_W'(1);
            end
            LOCKOUT: begin
                if (cnt_q == LOCK_LAST) begin
                    fail_d  = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = LOCKOUT;
                cnt_d    = '0;
                idx_d    = '0;
                digits_d = '0;
                abort_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            digits_q      <= '0;
            cnt_q         <= '0;
            fail_q        <= '0;
            abort_q       <= 1'b0;
            prev_enter_q  <= 1'b1;
            prev_relock_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            digits_q      <= digits_d;
            cnt_q         <= cnt_d;
            fail_q        <= fail_d;
            abort_q       <= abort_d;
            prev_enter_q  <= bus.signal_in[7];
            prev_relock_q <= bus.signal_in[6];
        end
    end

    assign bus.unlocked   = (state_q == GRANTED);
    assign bus.alarm      = (state_q == DENIED) || (state_q == LOCKOUT);
    assign bus.locked_out = (state_q == LOCKOUT);
    assign bus.state      = state_q;
    assign bus.fail_count = fail_q;
    assign bus.entry_idx  = idx_q;
endmodule

// File: tb/tb_code_entry_fsm.sv
// Bench for code_entry_fsm: directed scenarios plus random keypad traffic,
// checked every cycle against a queue-based behavioural model.
module tb_code_entry_fsm;
    localparam logic [15:0] CODE = 16'hA5C3;
    localparam int MAXF  = 3;
    localparam int TO    = 20;
    localparam int DENY  = 16;
    localparam int LOCK  = 50;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    code_entry_if bus ();

    code_entry_fsm #(
        .CODE          (CODE),
        .MAX_FAILS     (MAXF),
        .ENTRY_TIMEOUT (TO),
        .DENY_HOLD     (DENY),
        .LOCKOUT_CYCLES(LOCK)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model: states numbered as the published encoding, digits kept
    // as a queue, one "age" count of cycles spent waiting in the current phase.
    int m_state, m_fail, m_age;
    bit m_abort, m_prev_e, m_prev_r;
    int m_digits[$];

    function automatic int code_digit(input int i);
        return int'((CODE >> (12 - 4 * i)) & 16'hF);
    endfunction

    task automatic model_reset();
        m_state = 0; m_fail = 0; m_age = 0; m_abort = 0;
        m_prev_e = 1; m_prev_r = 1;
        m_digits.delete();
    endtask

    task automatic model_clock(input logic [7:0] v);
        bit er, rr, ok;
        er = v[7] && !m_prev_e;
        rr = v[6] && !m_prev_r;
        m_prev_e = v[7];
        m_prev_r = v[6];
        case (m_state)
            0: if (er) begin m_digits = {int'(v[3:0])}; m_age = 0; m_state = 1; end
            1: begin
                if (er) begin
                    m_digits.push_back(int'(v[3:0]));
                    m_age = 0;
                    if (m_digits.size() == 4) begin m_abort = 0; m_state = 2; end
                end else if (m_age == TO - 1) begin
                    m_abort = 1; m_state = 2;
                end else m_age++;
            end
            2: begin
                ok = !m_abort && (m_digits.size() == 4);
                for (int i = 0; i < m_digits.size(); i++)
                    if (m_digits[i] != code_digit(i)) ok = 0;
                m_digits.delete();
                m_age = 0;
                if (ok) begin m_fail = 0; m_state = 3; end
                else begin
                    if (m_fail < 7) m_fail++;
                    m_state = (m_fail >= MAXF) ? 5 : 4;
                end
            end
            3: if (rr) m_state = 0;
            4: if (m_age == DENY - 1) m_state = 0; else m_age++;
            5: if (m_age == LOCK - 1) begin m_fail = 0; m_state = 0; end else m_age++;
            default: begin m_state = 5; m_age = 0; m_digits.delete(); end
        endcase
    endtask

    task automatic compare_outputs();
        int exp_idx;
        exp_idx = (m_state == 1) ? (m_digits.size() % 4) : 0;
        check("state", 32'(bus.state), 32'(m_state));
        check("fail_count", 32'(bus.fail_count), 32'(m_fail));
        check("entry_idx", 32'(bus.entry_idx), 32'(exp_idx));
        check("flags", {29'd0, bus.unlocked, bus.alarm, bus.locked_out},
              {29'd0, m_state == 3, (m_state == 4) || (m_state == 5), m_state == 5});
    endtask

    // Called at a falling edge: drive, clock DUT and model, sample at next fall.
    task automatic step(input logic [7:0] v);
        bus.signal_in = v;
        @(posedge clk);
        model_clock(v);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic press(input logic [3:0] d);
        step({2'b00, 2'($urandom_range(0, 3)), d});
        step({2'b10, 2'($urandom_range(0, 3)), d});
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] t;
            t = c >> (12 - 4 * i);
            press(t[3:0]);
        end
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound && m_state != 0; i++) step(8'h00);
        check("idle_reached", 32'(bus.state), 32'd0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_n = 1'b0;
        bus.signal_in = 8'h80;
        model_reset();
        repeat (3) @(negedge clk);
        compare_outputs();
        rst_n = 1'b1;

        // ENTER held high through reset release is not an edge
        repeat (10) step(8'h80);
        check("hold80_state", 32'(bus.state), 32'd0);
        step(8'h00);

        // Correct code, then relock
        enter_code(16'hA5C3);
        check("grant_check", 32'(bus.state), 32'd2);
        step(8'h00);
        check("grant_unlocked", 32'(bus.unlocked), 32'd1);
        step(8'h40);
        check("relock_state", 32'(bus.state), 32'd0);
        step(8'h00);

        // Two denials of exactly DENY cycles each
        for (int k = 0; k < 2; k++) begin
            enter_code(16'hA5C2);
            step(8'h00);
            check("deny_fails", 32'(bus.fail_count), 32'(k + 1));
            cnt = 0;
            while (bus.alarm && cnt < 100) begin cnt++; step(8'h00); end
            check("deny_len", 32'(cnt), 32'd16);
        end

        // Third failure locks out; ENTER/RELOCK pulses ignored meanwhile
        enter_code(16'hA5C2);
        step(8'h00);
        check("lock_state", 32'(bus.state), 32'd5);
        cnt = 0;
        while (bus.locked_out && cnt < 200) begin
            cnt++;
            step((cnt % 2 == 1) ? 8'hCA : 8'h03);
        end
        check("lock_len", 32'(cnt), 32'd50);
        check("lock_fail_clr", 32'(bus.fail_count), 32'd0);
        step(8'h00);

        // Entry timeout after two digits
        press(4'hA); press(4'h5);
        repeat (19) step(8'h00);
        check("pre_timeout", 32'(bus.state), 32'd1);
        step(8'h00);
        check("timeout_check", 32'(bus.state), 32'd2);
        step(8'h00);
        check("timeout_deny", 32'(bus.state), 32'd4);
        check("timeout_fail", 32'(bus.fail_count), 32'd1);
        wait_idle(100);

        // ENTER edge landing on the timeout cycle wins
        press(4'hA); press(4'h5);
        repeat (19) step(8'h00);
        step(8'h8C);
        check("edge_on_to_state", 32'(bus.state), 32'd1);
        check("edge_on_to_idx", 32'(bus.entry_idx), 32'd3);
        press(4'h3);
        step(8'h00);
        check("edge_on_to_grant", 32'(bus.unlocked), 32'd1);

        // ENTER and RELOCK together in GRANTED: relock only
        step(8'hC0);
        check("both_state", 32'(bus.state), 32'd0);
        step(8'h00);
        check("both_idx", 32'(bus.entry_idx), 32'd0);

        // Illegal state code is fail-secure
        force dut.state_q = 3'd6;
        #1;
        m_state = 6;
        compare_outputs();
        release dut.state_q;
        step(8'h00);
        check("illegal_lock", 32'(bus.state), 32'd5);
        wait_idle(200);

        // Asynchronous reset mid-entry
        press(4'hA); press(4'h5);
        check("arst_pre_idx", 32'(bus.entry_idx), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h85);
        step(8'h00);

        // Random keypad traffic, biased toward the correct digits
        for (int b = 0; b < 40; b++) begin
            int len;
            len = int'($urandom_range(1, 30));
            for (int i = 0; i < len; i++) begin
                logic [3:0] d;
                logic       en, rl;
                d  = ($urandom_range(0, 1) == 1) ? 4'(code_digit(m_digits.size() % 4))
                                                 : 4'($urandom_range(0, 15));
                en = ($urandom_range(0, 2) == 0);
                rl = ($urandom_range(0, 9) == 0);
                step({en, rl, 2'($urandom_range(0, 3)), d});
            end
            if ($urandom_range(0, 3) == 0) repeat (22) step(8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
